fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Parametrised instruction-fetch front end for the RISC-V pipeline.
- Generates sequential PC requests to instruction memory and tracks in-flight requests.
- Buffers returned instruction words, each paired with its PC, in a DEPTH-entry FIFO feeding decode.
- Supports redirect (branch/jump) flush, including discard of stale in-flight responses.

Parameters:
- XLEN, 32: PC/address width.
- ILEN, 32: instruction word width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset; must be 4-byte aligned.

Ports:
- clock, input, 1: single clock, all logic on posedge.
- reset, input, 1: synchronous, active-high.
- req_valid, output, 1: memory request valid.
- req_ready, input, 1: memory accepts request.
- req_addr, output, XLEN: fetch address.
- rsp_valid, input, 1: memory response valid; in order, no backpressure.
- rsp_data, input, ILEN: instruction word.
- out_valid, output, 1: FIFO head valid to decode.
- out_ready, input, 1: decode consumes head.
- out_pc, output, XLEN: PC of head entry.
- out_ins, output, ILEN: instruction at head.
- redirect_valid, input, 1: flush and restart fetch.
- redirect_pc, input, XLEN: new fetch PC; bits [1:0] ignored (treated as 0).
- proto_err, output, 1: sticky; set by a response with nothing in flight.

Behaviour:
- Reset (synchronous, active-high; wins over every other input):
  - fetch_pc = RESET_PC and rsp_pc = RESET_PC.
  - occupancy, inflight and drop counters = 0; FIFO pointers = 0.
  - req_valid = 0, out_valid = 0, proto_err = 0.
  - out_pc and out_ins are don't-care while out_valid = 0.
- Counters are $clog2(DEPTH+1) bits wide. PC arithmetic is modulo 2^XLEN (wraps silently).
- Request side:
  - req_valid = !reset && !redirect_valid && (occupancy + inflight < DEPTH).
  - req_valid is registered-free combinational from state.
  - req_addr = fetch_pc.
  - req_fire = req_valid && req_ready. On req_fire: fetch_pc += 4, inflight += 1.
- Response side:
  - Every rsp_valid with inflight > 0 decrements inflight.
  - If drop > 0: the response is discarded and drop -= 1.
  - Otherwise: write {rsp_pc, rsp_data} to the FIFO tail, occupancy += 1, rsp_pc += 4.
  - Credit rule guarantees the FIFO never overflows.
  - rsp_valid with inflight == 0: ignored, and proto_err is set to 1. It stays 1 until reset.
- Output side:
  - out_valid = (occupancy != 0).
  - out_pc and out_ins come from the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - The FIFO is full-bypass-free: a word written this cycle is visible no earlier than the next cycle (min latency req_fire to out_valid = memory latency + 1).
- Redirect (redirect_valid = 1 in cycle N):
  - FIFO is flushed; occupancy = 0 and out_valid = 0 in cycle N+1. A pop in cycle N is ignored.
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - req_valid = 0 in cycle N; first redirected request in cycle N+1.
  - drop_next = inflight - (rsp_valid ? 1 : 0). A response arriving in cycle N is itself discarded.
  - Back-to-back redirects: the last one wins, and drop accumulates correctly because inflight already includes prior drops.
- Reset mid-operation: all state is cleared in the next cycle. The memory side must also be reset, because responses to pre-reset requests are unaccounted and will raise proto_err.

Test Plan:
- Streaming: reset, then req_ready = 1, memory with 1-cycle latency returning rsp_data = addr ^ 32'hA5A5_0000, out_ready = 1.
  - Required: req_addr = 0x0, 0x4, 0x8, …
  - Required: (out_pc, out_ins) = (0x0, 0xA5A5_0000), (0x4, 0xA5A5_0004), … with no gaps after fill.
- Backpressure: out_ready = 0, DEPTH = 4.
  - Required: exactly 4 req_fire, then req_valid stays 0.
  - Required: out_pc holds 0x0.
  - Releasing out_ready for one cycle yields exactly one new request (addr 0x10).
- Redirect with 2 in flight (3-cycle memory latency): redirect_pc = 0x100.
  - Required: both stale responses discarded.
  - Required: next req_addr = 0x100; first out_pc = 0x100.
  - Required: no entry from the old stream appears.
- Redirect coinciding with rsp_valid, an out_ready pop and a 0x103 target.
  - Required: the response is dropped and the FIFO is empty next cycle.
  - Required: req_addr = 0x100.
- Spurious response: rsp_valid = 1 with inflight = 0.
  - Required: proto_err = 1 next cycle and stays 1; occupancy unchanged.
  - Required: proto_err = 0 after reset.
- Reset mid-stream with FIFO at 3 entries.
  - Required: out_valid = 0 and req_valid = 0 in the reset cycle's successor.
  - Required: fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: memory request/response, decode output, redirect and error flag.
// master is the fetch_queue side; slave is the memory/decode/branch environment.
interface fetch_queue_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned ILEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_ins;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            proto_err;

    modport master (
        output req_valid, req_addr, out_valid, out_pc, out_ins, proto_err,
        input  req_ready, rsp_valid, rsp_data, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_pc, out_ins, proto_err,
        output req_ready, rsp_valid, rsp_data, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC requests, in-flight credit tracking,
// DEPTH-entry {pc, instruction} FIFO towards decode, redirect flush with stale-response drop.
module fetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      ILEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            proto_err_q, proto_err_d;

    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [ILEN-1:0] ins_mem [DEPTH];

    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_take;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_pc_al;

    // A request is only issued when its eventual response is guaranteed a FIFO slot.
    assign credit_used    = {1'b0, occ_q} + {1'b0, inflight_q};
    assign bus.req_valid  = !reset && !bus.redirect_valid && (credit_used < DEPTH_W);
    assign bus.req_addr   = fetch_pc_q;
    assign req_fire       = bus.req_valid && bus.req_ready;

    assign rsp_take       = bus.rsp_valid && (inflight_q != '0);
    assign push           = rsp_take && (drop_q == '0) && !bus.redirect_valid;
    assign pop            = bus.out_valid && bus.out_ready && !bus.redirect_valid;
    assign redirect_pc_al = {bus.redirect_pc[XLEN-1:2], 2'b00};

    assign bus.out_valid  = (occ_q != '0);
    assign bus.out_pc     = pc_mem[rd_ptr_q];
    assign bus.out_ins    = ins_mem[rd_ptr_q];
    assign bus.proto_err  = proto_err_q;

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        rsp_pc_d    = rsp_pc_q;
        occ_d       = occ_q;
        drop_d      = drop_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        inflight_d  = inflight_q + CW'(req_fire) - CW'(rsp_take);
        proto_err_d = proto_err_q | (bus.rsp_valid && (inflight_q == '0));

        if (bus.redirect_valid) begin
            // Everything still in flight belongs to the old stream, except a response
            // landing this very cycle, which is discarded right here.
            fetch_pc_d = redirect_pc_al;
            rsp_pc_d   = redirect_pc_al;
            occ_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = inflight_q - CW'(rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (rsp_take && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            rsp_pc_q    <= RESET_PC;
            occ_q       <= '0;
            inflight_q  <= '0;
            drop_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_pc_q    <= rsp_pc_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            drop_q      <= drop_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage needs no reset: entries are only observed once occupancy covers them.
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= rsp_pc_q;
            ins_mem[wr_ptr_q] <= bus.rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small fixed-latency memory model
// that answers each request with addr ^ 32'hA5A5_0000.
module tb_fetch_queue;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   fires;
    int   lat;
    logic spur;

    logic [2:0]  s_v;
    logic [31:0] s_a [3];

    fetch_queue_if #(.XLEN(32), .ILEN(32)) bus ();

    fetch_queue #(
        .XLEN     (32),
        .ILEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: response appears lat cycles after the accepting edge.
    always @(posedge clock) begin
        if (reset) begin
            s_v <= '0;
        end else begin
            s_v    <= {s_v[1:0], bus.req_valid && bus.req_ready};
            s_a[0] <= bus.req_addr;
            s_a[1] <= s_a[0];
            s_a[2] <= s_a[1];
        end
    end

    assign bus.rsp_valid = s_v[lat-1] | spur;
    assign bus.rsp_data  = s_a[lat-1] ^ 32'hA5A5_0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.req_ready      = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        spur               = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        n_tests            = 0;
        n_fail             = 0;
        fires              = 0;
        lat                = 1;
        spur               = 1'b0;
        reset              = 1'b1;
        bus.req_ready      = 1'b1;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Reset state, including req_valid held low while reset is asserted.
        cyc();
        #1;
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_proto_err", bus.proto_err, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("rst_rel_req_valid", bus.req_valid, 1);
        chk("rst_rel_req_addr", bus.req_addr, 0);
        chk("rst_rel_out_valid", bus.out_valid, 0);

        // Streaming with 1-cycle memory and decode always ready.
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("stream_req_valid", bus.req_valid, 1);
            chk("stream_req_addr", bus.req_addr, 4 * i);
            if (i >= 2) begin
                chk("stream_out_valid", bus.out_valid, 1);
                chk("stream_out_pc", bus.out_pc, 4 * (i - 2));
                chk("stream_out_ins", bus.out_ins, (4 * (i - 2)) ^ 32'hA5A5_0000);
            end else begin
                chk("stream_fill_empty", bus.out_valid, 0);
            end
            cyc();
            #1;
        end

        // Backpressure: decode stalled, credits cap requests at DEPTH.
        do_reset();
        bus.req_ready = 1'b1;
        #1;
        fires = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.req_valid && bus.req_ready) fires++;
            cyc();
            #1;
        end
        chk("bp_fire_count", fires, 4);
        chk("bp_req_valid_low", bus.req_valid, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_out_pc_hold", bus.out_pc, 0);
        chk("bp_out_ins_hold", bus.out_ins, 32'hA5A5_0000);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        #1;
        chk("bp_release_req_valid", bus.req_valid, 1);
        chk("bp_release_req_addr", bus.req_addr, 32'h10);
        chk("bp_release_out_pc", bus.out_pc, 4);
        fires = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.req_valid && bus.req_ready) fires++;
            cyc();
            #1;
        end
        chk("bp_release_fire_count", fires, 1);
        chk("bp_refull_req_valid", bus.req_valid, 0);
        chk("bp_refull_out_pc", bus.out_pc, 4);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset();
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("rd3_c0_addr", bus.req_addr, 0);
        cyc();
        #1;
        chk("rd3_c1_addr", bus.req_addr, 4);
        cyc();
        bus.req_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        chk("rd3_redir_req_valid", bus.req_valid, 0);
        cyc();
        bus.redirect_valid = 1'b0;
        bus.req_ready      = 1'b1;
        #1;
        chk("rd3_new_req_valid", bus.req_valid, 1);
        chk("rd3_new_req_addr", bus.req_addr, 32'h100);
        chk("rd3_c3_empty", bus.out_valid, 0);
        cyc();
        #1;
        chk("rd3_c4_addr", bus.req_addr, 32'h104);
        chk("rd3_c4_empty", bus.out_valid, 0);
        cyc();
        bus.req_ready = 1'b0;
        #1;
        chk("rd3_c5_empty", bus.out_valid, 0);
        cyc();
        #1;
        chk("rd3_c6_empty", bus.out_valid, 0);
        cyc();
        #1;
        chk("rd3_first_valid", bus.out_valid, 1);
        chk("rd3_first_pc", bus.out_pc, 32'h100);
        chk("rd3_first_ins", bus.out_ins, 32'hA5A5_0100);
        cyc();
        #1;
        chk("rd3_second_pc", bus.out_pc, 32'h104);
        chk("rd3_second_ins", bus.out_ins, 32'hA5A5_0104);
        cyc();
        #1;
        chk("rd3_drained", bus.out_valid, 0);
        chk("rd3_idle_req_valid", bus.req_valid, 1);

        // Redirect coinciding with a response and a pop, unaligned target.
        lat = 1;
        do_reset();
        bus.req_ready = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        cyc();
        cyc();
        #1;
        chk("rdc_c2_out_pc", bus.out_pc, 0);
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        chk("rdc_redir_req_valid", bus.req_valid, 0);
        chk("rdc_redir_out_valid", bus.out_valid, 1);
        chk("rdc_redir_out_pc", bus.out_pc, 4);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rdc_flushed", bus.out_valid, 0);
        chk("rdc_req_valid", bus.req_valid, 1);
        chk("rdc_req_addr", bus.req_addr, 32'h100);
        cyc();
        #1;
        chk("rdc_c5_empty", bus.out_valid, 0);
        chk("rdc_c5_addr", bus.req_addr, 32'h104);
        cyc();
        #1;
        chk("rdc_first_valid", bus.out_valid, 1);
        chk("rdc_first_pc", bus.out_pc, 32'h100);
        chk("rdc_first_ins", bus.out_ins, 32'hA5A5_0100);

        // Spurious response with nothing in flight.
        do_reset();
        bus.req_ready = 1'b1;
        #1;
        cyc();
        bus.req_ready = 1'b0;
        cyc();
        #1;
        chk("sp_pre_proto_err", bus.proto_err, 0);
        chk("sp_pre_out_valid", bus.out_valid, 1);
        spur = 1'b1;
        cyc();
        spur = 1'b0;
        #1;
        chk("sp_proto_err_set", bus.proto_err, 1);
        chk("sp_out_valid", bus.out_valid, 1);
        chk("sp_out_pc", bus.out_pc, 0);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        #1;
        chk("sp_occ_unchanged", bus.out_valid, 0);
        chk("sp_proto_err_sticky1", bus.proto_err, 1);
        cyc();
        cyc();
        #1;
        chk("sp_proto_err_sticky2", bus.proto_err, 1);
        do_reset();
        #1;
        chk("sp_proto_err_cleared", bus.proto_err, 0);

        // Reset mid-stream with three entries buffered.
        do_reset();
        bus.req_ready = 1'b1;
        #1;
        repeat (4) cyc();
        #1;
        chk("mr_pre_out_valid", bus.out_valid, 1);
        chk("mr_pre_req_valid", bus.req_valid, 0);
        chk("mr_pre_out_pc", bus.out_pc, 0);
        reset = 1'b1;
        cyc();
        #1;
        chk("mr_next_out_valid", bus.out_valid, 0);
        chk("mr_next_req_valid", bus.req_valid, 0);
        chk("mr_next_proto_err", bus.proto_err, 0);
        cyc();
        reset = 1'b0;
        #1;
        chk("mr_restart_req_valid", bus.req_valid, 1);
        chk("mr_restart_addr", bus.req_addr, 0);
        chk("mr_restart_empty", bus.out_valid, 0);
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        #1;
        chk("mr_restart_out_valid", bus.out_valid, 1);
        chk("mr_restart_out_pc", bus.out_pc, 0);
        chk("mr_restart_out_ins", bus.out_ins, 32'hA5A5_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
